program_rom_sync: RTL and testbench

// - Parametrised program memory for the PIC-style core; successor to the fixed 14x2K combinational program ROM.
// - Synchronous read with one-cycle latency; core fetch unit sits on the rd_* port.
// - In-system load port (valid/ready stream) lets the testbench/UART loader rewrite the program without re-synthesis.
// - Loader FSM owns the array during a load; fetches are blocked and return NOP.

---
 rtl/program_rom_sync.sv | 111 +++++++++++
 tb/tb_program_rom_sync.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/program_rom_sync.sv
// Program memory: one-cycle synchronous fetch plus a valid/ready in-system loader that owns the array while loading.
// Optional ld_checksum output enabled by defining PROGRAM_ROM_CHECKSUM_EN.
module program_rom_sync #(
  parameter int                 DATA_W    = 14,
  parameter int                 ADDR_W    = 11,
  parameter int                 DEPTH     = 2048,
  parameter logic [DATA_W-1:0]  NOP_WORD  = '0,
  parameter string              INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count
`ifdef PROGRAM_ROM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] ld_checksum
`endif
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_PTR = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              hs;
  logic              fin;
  logic              start_ok;
  logic              in_range;

  // Power-up image; reset never touches the array.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = NOP_WORD;
  end

  assign hs       = (state == LOAD) && ld_valid;
  assign fin      = hs && (ld_last || (ptr == LAST_PTR));
  assign start_ok = (state == IDLE) && ld_start;
  assign in_range = {1'b0, rd_addr} < DEPTH_L;

  assign ld_ready = (state == LOAD);
  assign ld_busy  = (state == LOAD);
  assign ld_done  = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ld_start) state_nxt = LOAD;
      LOAD:    if (fin)      state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      ptr      <= '0;
      ld_count <= '0;
    end else if (hs) begin
      ptr      <= ptr + 1'b1;
      ld_count <= ld_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && hs) mem[ptr] <= ld_data;
  end

  // Loader owns the array while busy, so reads and writes never share a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= NOP_WORD;
      rd_valid <= 1'b0;
    end else if (ld_busy) begin
      rd_data  <= NOP_WORD;
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_data  <= in_range ? mem[rd_addr[IDX_W-1:0]] : NOP_WORD;
      rd_valid <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

`ifdef PROGRAM_ROM_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || start_ok) ld_checksum <= '0;
    else if (hs)           ld_checksum <= ld_checksum + ld_data;
  end
`endif

endmodule

// File: tb/tb_program_rom_sync.sv
// Directed bench for program_rom_sync (DEPTH=16 so overflow and out-of-range cases are reachable).
module tb_program_rom_sync;
  localparam int DATA_W = 14;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;
  logic [ADDR_W:0]   ld_count;
`ifdef PROGRAM_ROM_CHECKSUM_EN
  logic [DATA_W-1:0] ld_checksum;
`endif

  int errors = 0;
  int checks = 0;

  program_rom_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done), .ld_count(ld_count)
`ifdef PROGRAM_ROM_CHECKSUM_EN
    , .ld_checksum(ld_checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp_data;
    logic              exp_valid;
  } vec_t;

  vec_t vecs [9];
  logic [DATA_W-1:0] words [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; rd_en = 1'b0; rd_addr = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    words[0] = 14'h3001; words[1] = 14'h07A2; words[2] = 14'h0BA4;

    vecs[0] = '{1'b1, 11'h000, 14'h3001, 1'b1};
    vecs[1] = '{1'b1, 11'h001, 14'h07A2, 1'b1};
    vecs[2] = '{1'b1, 11'h002, 14'h0BA4, 1'b1};
    vecs[3] = '{1'b0, 11'h001, 14'h0BA4, 1'b0};
    vecs[4] = '{1'b1, 11'h003, 14'h0000, 1'b1};
    vecs[5] = '{1'b1, 11'h010, 14'h0000, 1'b1};
    vecs[6] = '{1'b1, 11'h7FF, 14'h0000, 1'b1};
    vecs[7] = '{1'b1, 11'h002, 14'h0BA4, 1'b1};
    vecs[8] = '{1'b0, 11'h000, 14'h0BA4, 1'b0};

    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_ld_ready", 32'(ld_ready), 32'h0);
    chk("rst_ld_busy", 32'(ld_busy), 32'h0);
    chk("rst_ld_done", 32'(ld_done), 32'h0);
    chk("rst_ld_count", 32'(ld_count), 32'h0);

    // Unloaded word and out-of-range address both return NOP with valid.
    rd_en = 1'b1; rd_addr = 11'h005; tick();
    chk("blank_data", 32'(rd_data), 32'h0);
    chk("blank_valid", 32'(rd_valid), 32'h1);
    rd_addr = 11'h7FF; tick();
    chk("oor_data", 32'(rd_data), 32'h0);
    chk("oor_valid", 32'(rd_valid), 32'h1);
    rd_en = 1'b0;

    // Load three words with ld_valid toggling; fetches blocked throughout.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    chk("ld_busy_on", 32'(ld_busy), 32'h1);
    chk("ld_ready_on", 32'(ld_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b0; ld_data = 14'h3FFF; rd_en = 1'b1; rd_addr = 11'(i);
      tick();
      chk("busy_rd_valid", 32'(rd_valid), 32'h0);
      chk("busy_rd_data", 32'(rd_data), 32'h0);
      chk("gap_count", 32'(ld_count), 32'(i));
      ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 2);
      tick();
      chk("busy_rd_valid2", 32'(rd_valid), 32'h0);
      chk("busy_rd_data2", 32'(rd_data), 32'h0);
    end
    ld_valid = 1'b0; ld_last = 1'b0; rd_en = 1'b0;
    chk("done_pulse", 32'(ld_done), 32'h1);
    chk("done_busy", 32'(ld_busy), 32'h0);
    chk("done_ready", 32'(ld_ready), 32'h0);
    chk("done_count", 32'(ld_count), 32'h3);
`ifdef PROGRAM_ROM_CHECKSUM_EN
    chk("checksum3", 32'(ld_checksum), 32'h0347);
`endif
    tick();
    chk("done_once", 32'(ld_done), 32'h0);
    chk("count_hold", 32'(ld_count), 32'h3);

    for (int i = 0; i < 9; i++) begin
      rd_en = vecs[i].en; rd_addr = vecs[i].addr;
      tick();
      chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
    end

    // ld_start alongside a fetch: the fetch completes, then 20 words stream into a 16-word array.
    ld_start = 1'b1; rd_en = 1'b1; rd_addr = 11'h001;
    tick();
    ld_start = 1'b0; rd_en = 1'b0;
    chk("start_fetch_data", 32'(rd_data), 32'h07A2);
    chk("start_fetch_valid", 32'(rd_valid), 32'h1);
    chk("start_busy", 32'(ld_busy), 32'h1);
    chk("start_count_clr", 32'(ld_count), 32'h0);
    for (int i = 0; i < 20; i++) begin
      ld_valid = 1'b1; ld_data = 14'(14'h100 + i);
      #0;
      chk($sformatf("ovf_ready%0d", i), 32'(ld_ready), 32'(i < 16));
      chk($sformatf("ovf_done%0d", i), 32'(ld_done), 32'(i == 16));
      tick();
    end
    ld_valid = 1'b0;
    chk("ovf_count", 32'(ld_count), 32'd16);
`ifdef PROGRAM_ROM_CHECKSUM_EN
    chk("ovf_checksum", 32'(ld_checksum), 32'h1078);
`endif
    rd_en = 1'b1; rd_addr = 11'h00F; tick();
    chk("ovf_last_word", 32'(rd_data), 32'h10F);
    rd_addr = 11'h000; tick();
    chk("ovf_first_word", 32'(rd_data), 32'h100);
    rd_en = 1'b0;

    // Reset after two words; ld_start mid-load must not restart the count.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 14'h2AA; tick();
    ld_data = 14'h2AB; ld_start = 1'b1; tick();
    ld_start = 1'b0; ld_valid = 1'b0;
    chk("mid_start_ignored", 32'(ld_count), 32'h2);
    chk("mid_busy", 32'(ld_busy), 32'h1);
    reset = 1'b1; ld_valid = 1'b1; ld_data = 14'h3333; tick();
    reset = 1'b0; ld_valid = 1'b0;
    chk("rst_mid_busy", 32'(ld_busy), 32'h0);
    chk("rst_mid_done", 32'(ld_done), 32'h0);
    chk("rst_mid_count", 32'(ld_count), 32'h0);
    tick();
    chk("rst_mid_done2", 32'(ld_done), 32'h0);
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1; rd_addr = 11'(i); tick();
      chk($sformatf("rst_mem%0d", i), 32'(rd_data),
          (i == 0) ? 32'h2AA : (i == 1) ? 32'h2AB : 32'(32'h100 + i));
    end
    rd_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
